lfsr_seed_loader: RTL
=====================

Name: lfsr_seed_loader

Overview:
- Write-direction counterpart of the LFSR chain readout path: loads a host-supplied seed pattern into the on-chip 2-lane LFSR scan chains.
- Pops 16 x 32-bit words from the single-clock side of the host pipe-in FIFO and buffers them as two lane images (256 bits each).
- Serialises the images onto lfsr_out[1:0] with a slow, glitch-free lfsr_clk.
- Sits beside the readout controller; both share the chip LFSR clock pin through a top-level mux.

Parameters:
- CHAIN_LEN, 256, bits per lane; must be a multiple of 32.
- WORDS_PER_LANE, CHAIN_LEN/32, words fetched per lane; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- load_trigger  input  1  start pulse; sampled only in IDLE.
- shift_cycle  input  9  number of lfsr_clk pulses to issue; sampled when load_trigger is accepted.
- in_fifo_dout  input  32  FIFO read data; valid the second cycle after in_fifo_rd_en is registered high.
- in_fifo_empty  input  1  FIFO empty flag.
- in_fifo_rd_en  output  1  registered FIFO pop; one-cycle pulse per word.
- lfsr_clk  output  1  chain shift clock to chip.
- lfsr_out  output  2  serial data to chain; [0]=lane 0, [1]=lane 1.
- busy  output  1  high from the cycle after trigger acceptance until the cycle done is asserted.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - All outputs 0.
  - Lane buffers, word_cnt, bit_cnt and the latched shift length are 0.
  - FSM returns to IDLE.
  - Reset asserted mid-operation aborts immediately. No partial-word recovery; words already popped are lost.
- States: IDLE, FETCH, WAIT, CAPTURE, SH_DATA, SH_HIGH, SH_HOLD, DONE.
- IDLE:
  - Outputs 0.
  - On load_trigger: latch len = min(shift_cycle, CHAIN_LEN), clear buffers, word_cnt=0 -> FETCH.
  - load_trigger outside IDLE is ignored.
- FETCH: if !in_fifo_empty, drive in_fifo_rd_en<=1 -> WAIT; otherwise stall in FETCH indefinitely with rd_en=0.
- WAIT: in_fifo_rd_en<=0 -> CAPTURE.
- CAPTURE:
  - Store in_fifo_dout into a lane buffer:
    - word_cnt 0..7 -> lane 0 bits [32*word_cnt +: 32].
    - word_cnt 8..15 -> lane 1 bits [32*(word_cnt-8) +: 32].
  - Then word_cnt++.
  - After word 15: if len==0 -> DONE, else bit_cnt=0 -> SH_DATA.
  - Otherwise -> FETCH.
  - Cost: 3 cycles per word minimum.
- SH_DATA: lfsr_clk<=0; lfsr_out[i]<=lane_i[0] -> SH_HIGH.
- SH_HIGH: lfsr_clk<=1; lfsr_out held -> SH_HOLD.
- SH_HOLD:
  - lfsr_clk<=0; lfsr_out held.
  - Both lane buffers shift right by 1, filling the MSB with 0; bit_cnt++.
  - If bit_cnt==len-1 -> DONE, else -> SH_DATA.
- Shift timing:
  - Data changes only while lfsr_clk is low.
  - Data is stable 1 cycle before the rising edge and 1 cycle after the falling edge.
  - 3 clk cycles per shifted bit.
  - Bit order is LSB of word 0 first per lane.
- DONE: done<=1 for exactly one cycle; lfsr_clk=0, lfsr_out=0 -> IDLE. busy is low in the DONE cycle.
- Boundary cases:
  - shift_cycle > 256 clamps to 256.
  - shift_cycle == 0 still fetches all 16 words (keeps FIFO framing) and issues no lfsr_clk pulses.
  - The FIFO going empty mid-frame stalls in FETCH only.
- Total latency with a non-empty FIFO: 48 + 3*len + 1 cycles from trigger acceptance to done.

Optional Feature:
- Macro: LFSR_LOAD_CHECKSUM_EN.
- When defined:
  - Adds output load_checksum [31:0], reset 0.
  - Cleared on trigger acceptance.
  - XOR-accumulates every captured word in CAPTURE.
  - Holds its value after DONE until the next trigger.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- FIFO preloaded with words 0x00000001..0x00000010, shift_cycle=256, trigger -> exactly 16 rd_en pulses and 256 lfsr_clk pulses. Lane 0 sequence starts 1,0,0... (word0 LSB); lane 1's first 32 bits = 0x00000009 LSB-first. done is asserted at cycle 48+768+1 after acceptance.
- shift_cycle=0 -> 16 pops, zero lfsr_clk rising edges, done after 49 cycles.
- shift_cycle=300 -> exactly 256 lfsr_clk pulses.
- FIFO holds 10 words; remaining 6 pushed 100 cycles later -> FSM stalls in FETCH, rd_en stays 0 while empty, and final lane data is correct.
- rst asserted during SH_HIGH -> lfsr_clk, lfsr_out, busy and done are 0 immediately; a subsequent trigger restarts cleanly. A trigger pulsed while busy -> no effect.
- With LFSR_LOAD_CHECKSUM_EN and 16 words all 0xA5A5A5A5 -> load_checksum=0x00000000. With words 0x1..0x10 -> load_checksum=0x00000010.

Source files
------------

// File: rtl/lfsr_seed_loader.sv
// lfsr_seed_loader: pops 2*CHAIN_LEN/32 words from the host pipe-in FIFO,
// buffers them as two lane images and shifts them into the chip's two LFSR
// scan chains with a slow, glitch-free lfsr_clk (3 system clocks per bit).
// Optional build macro LFSR_LOAD_CHECKSUM_EN adds a 32-bit XOR checksum
// output (load_checksum) over all captured words.
module lfsr_seed_loader #(
    parameter int CHAIN_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_trigger,
    input  logic [8:0]  shift_cycle,
    input  logic [31:0] in_fifo_dout,
    input  logic        in_fifo_empty,
    output logic        in_fifo_rd_en,
    output logic        lfsr_clk,
    output logic [1:0]  lfsr_out,
    output logic        busy,
    output logic        done
`ifdef LFSR_LOAD_CHECKSUM_EN
    ,
    output logic [31:0] load_checksum
`endif
);

    localparam int WORDS_PER_LANE = CHAIN_LEN / 32;
    localparam int TOTAL_WORDS    = 2 * WORDS_PER_LANE;
    localparam int WCW            = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
    localparam int LW             = $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        SH_DATA = 3'd4,
        SH_HIGH = 3'd5,
        SH_HOLD = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d;
    logic [LW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]        len_q, len_d;
    logic [CHAIN_LEN-1:0] lane0_q, lane0_d;
    logic [CHAIN_LEN-1:0] lane1_q, lane1_d;
    logic                 rd_en_q, rd_en_d;
    logic                 lfsr_clk_q, lfsr_clk_d;
    logic [1:0]           lfsr_out_q, lfsr_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef LFSR_LOAD_CHECKSUM_EN
    logic [31:0]          csum_q, csum_d;
`endif

    logic                 last_word;
    logic                 shift_last;
    logic                 in_lane1;
    logic [WCW-1:0]       lane_word;
    logic [31:0]          req_len;

    assign last_word  = (word_cnt_q == WCW'(TOTAL_WORDS - 1));
    assign shift_last = (bit_cnt_q == (len_q - LW'(1)));
    assign in_lane1   = !(word_cnt_q < WCW'(WORDS_PER_LANE));
    assign lane_word  = in_lane1 ? (word_cnt_q - WCW'(WORDS_PER_LANE)) : word_cnt_q;
    assign req_len    = {23'd0, shift_cycle};

    // State register; reset aborts any transfer in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: fetch three cycles per word, then three cycles per shifted bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_trigger) state_d = FETCH;
            FETCH:   if (!in_fifo_empty) state_d = WAIT;
            WAIT:    state_d = CAPTURE;
            CAPTURE: begin
                if (!last_word)        state_d = FETCH;
                else if (len_q == '0)  state_d = DONE;
                else                   state_d = SH_DATA;
            end
            SH_DATA: state_d = SH_HIGH;
            SH_HIGH: state_d = SH_HOLD;
            SH_HOLD: state_d = shift_last ? DONE : SH_DATA;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs: data only changes on the edge that leaves SH_DATA,
    // so it is settled a full cycle on either side of the lfsr_clk high phase
    always_comb begin
        rd_en_d    = 1'b0;
        lfsr_clk_d = 1'b0;
        lfsr_out_d = 2'b00;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE:    busy_d = load_trigger;
            FETCH:   begin busy_d = 1'b1; rd_en_d = !in_fifo_empty; end
            WAIT:    busy_d = 1'b1;
            CAPTURE: busy_d = 1'b1;
            SH_DATA: begin busy_d = 1'b1; lfsr_out_d = {lane1_q[0], lane0_q[0]}; end
            SH_HIGH: begin busy_d = 1'b1; lfsr_clk_d = 1'b1; lfsr_out_d = lfsr_out_q; end
            SH_HOLD: begin busy_d = 1'b1; lfsr_out_d = lfsr_out_q; end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch clamped length, capture words into lane images, shift LSB-first
    always_comb begin
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        lane0_d    = lane0_q;
        lane1_d    = lane1_q;
`ifdef LFSR_LOAD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_trigger) begin
                    len_d      = (req_len > 32'(CHAIN_LEN)) ? LW'(CHAIN_LEN) : LW'(req_len);
                    word_cnt_d = '0;
                    lane0_d    = '0;
                    lane1_d    = '0;
`ifdef LFSR_LOAD_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            CAPTURE: begin
                for (int w = 0; w < WORDS_PER_LANE; w++) begin
                    if (lane_word == WCW'(w)) begin
                        if (in_lane1) lane1_d[w*32 +: 32] = in_fifo_dout;
                        else          lane0_d[w*32 +: 32] = in_fifo_dout;
                    end
                end
                word_cnt_d = word_cnt_q + WCW'(1);
                if (last_word) bit_cnt_d = '0;
`ifdef LFSR_LOAD_CHECKSUM_EN
                csum_d = csum_q ^ in_fifo_dout;
`endif
            end
            SH_HOLD: begin
                lane0_d   = {1'b0, lane0_q[CHAIN_LEN-1:1]};
                lane1_d   = {1'b0, lane1_q[CHAIN_LEN-1:1]};
                bit_cnt_d = bit_cnt_q + LW'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            len_q      <= '0;
            lane0_q    <= '0;
            lane1_q    <= '0;
            rd_en_q    <= 1'b0;
            lfsr_clk_q <= 1'b0;
            lfsr_out_q <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LFSR_LOAD_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            lane0_q    <= lane0_d;
            lane1_q    <= lane1_d;
            rd_en_q    <= rd_en_d;
            lfsr_clk_q <= lfsr_clk_d;
            lfsr_out_q <= lfsr_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef LFSR_LOAD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_fifo_rd_en = rd_en_q;
    assign lfsr_clk      = lfsr_clk_q;
    assign lfsr_out      = lfsr_out_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef LFSR_LOAD_CHECKSUM_EN
    assign load_checksum = csum_q;
`endif

endmodule
